// File: rtl/arbiter_wrr_if.sv
// arbiter_wrr_if
//   Request/grant bundle between the four requesters (U1..U4) and the
//   weighted round-robin arbiter. Bit mapping on every 4-bit field:
//   bit3 = U1, bit2 = U2, bit1 = U3, bit0 = U4.
//   req       : request lines, driven by the requesters
//   done      : release strobes, driven by the requesters
//   GRANT_O   : one-hot registered grant, driven by the arbiter
//   busy      : arbiter currently holds a grant
//   timeout_o : one-cycle pulse when the watchdog forced a release
//   Modports: master = requester side, slave = arbiter side.
interface arbiter_wrr_if;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] GRANT_O;
  logic       busy;
  logic       timeout_o;

  modport master (
    output req,
    output done,
    input  GRANT_O,
    input  busy,
    input  timeout_o
  );

  modport slave (
    input  req,
    input  done,
    output GRANT_O,
    output busy,
    output timeout_o
  );
endinterface

// File: rtl/arbiter_wrr.sv
// arbiter_wrr
//   Weighted round-robin arbiter with grant-hold handshake for four
//   requesters. Each requester owns a 3-bit credit that is spent one per
//   grant; when requests are pending but nobody has credit left, all
//   credits are reloaded to their weights. A granted requester keeps the
//   resource until it pulses done or drops req; one RELEASE cycle always
//   separates consecutive grants.
//   Optional watchdog: define ARB_WRR_TIMEOUT_EN to force a release after
//   HOLD_MAX grant cycles (timeout_o pulses during that RELEASE cycle).
//   Without the macro timeout_o is constant 0 and HOLD_MAX is unused.
// Ports
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : arbiter_wrr_if.slave (req, done in; GRANT_O, busy, timeout_o out)
// Parameters
//   W1..W4   : credit weights 1..7 (0 behaves as 1)
//   HOLD_MAX : watchdog limit in grant cycles, 2..255
module arbiter_wrr #(
  parameter int W1       = 1,
  parameter int W2       = 1,
  parameter int W3       = 1,
  parameter int W4       = 1,
  parameter int HOLD_MAX = 16
) (
  input logic          clk,
  input logic          rst,
  arbiter_wrr_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  // Weight 0 is promoted to 1 so a requester can never be starved forever.
  function automatic logic [2:0] norm_weight(input int w);
    logic [31:0] w_v;
    w_v = 32'(w);
    return (w == 0) ? 3'd1 : w_v[2:0];
  endfunction

  localparam logic [2:0] WT1_C = norm_weight(W1);
  localparam logic [2:0] WT2_C = norm_weight(W2);
  localparam logic [2:0] WT3_C = norm_weight(W3);
  localparam logic [2:0] WT4_C = norm_weight(W4);

  // Requester index: 0 = U1 .. 3 = U4.
  function automatic logic [2:0] wt_of(input logic [1:0] idx);
    case (idx)
      2'd0:    return WT1_C;
      2'd1:    return WT2_C;
      2'd2:    return WT3_C;
      2'd3:    return WT4_C;
      default: return 3'd1;
    endcase
  endfunction

  // One-hot grant code in bus bit order (U1 on bit3).
  function automatic logic [3:0] onehot_of(input logic [1:0] idx);
    case (idx)
      2'd0:    return 4'b1000;
      2'd1:    return 4'b0100;
      2'd2:    return 4'b0010;
      2'd3:    return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  state_t     state_r;
  state_t     state_nxt_s;
  logic [3:0] grant_r;
  logic [3:0] grant_nxt_s;
  logic       busy_r;
  logic       busy_nxt_s;
  logic       timeout_r;
  logic       timeout_nxt_s;
  logic [1:0] win_r;
  logic [1:0] last_r;
  logic [2:0] cred_r [4];
  logic [7:0] hold_r;

  logic [3:0] req_u_s;        // req re-ordered so index 0 = U1
  logic [2:0] cred_view_s [4]; // credits as seen by this cycle's selection
  logic       any_elig_s;
  logic       reload_s;
  logic       sel_vld_s;
  logic [1:0] sel_idx_s;
  logic       release_s;
  logic       timeout_hit_s;

  assign req_u_s = {bus.req[0], bus.req[1], bus.req[2], bus.req[3]};

  // Eligibility with current credits and the reload decision.
  always_comb begin
    any_elig_s = 1'b0;
    for (int u = 0; u < 4; u++) begin
      any_elig_s = any_elig_s | (req_u_s[u] & (cred_r[u] != 3'd0));
    end
    reload_s = (state_r == ST_IDLE) && (req_u_s != 4'b0000) && !any_elig_s;
  end

  // Reloaded credits take effect for the selection in the same cycle.
  always_comb begin
    for (int u = 0; u < 4; u++) begin
      if (reload_s) begin
        cred_view_s[u] = wt_of(2'(u));
      end else begin
        cred_view_s[u] = cred_r[u];
      end
    end
  end

  // Round-robin search starting at the requester after last.
  always_comb begin
    logic [1:0] cand_v;
    cand_v    = 2'd0;
    sel_vld_s = 1'b0;
    sel_idx_s = 2'd0;
    for (int i = 0; i < 4; i++) begin
      cand_v = last_r + 2'(i + 1);
      if (!sel_vld_s && req_u_s[cand_v] && (cred_view_s[cand_v] != 3'd0)) begin
        sel_vld_s = 1'b1;
        sel_idx_s = cand_v;
      end else begin
        sel_vld_s = sel_vld_s;
      end
    end
  end

  // Only the granted bit of done/req can release; grant_r masks the others.
  always_comb begin
    release_s = (state_r == ST_GRANT) && ((grant_r & (bus.done | ~bus.req)) != 4'b0000);
  end

`ifdef ARB_WRR_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST_C = 8'(HOLD_MAX - 1);

  // Watchdog fires on the last allowed grant cycle unless a normal release wins.
  always_comb begin
    timeout_hit_s = (state_r == ST_GRANT) && !release_s && (hold_r == HOLD_LAST_C);
  end
`else
  // No watchdog: a grant is only ever ended by the requester.
  always_comb begin
    timeout_hit_s = 1'b0;
  end
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (sel_vld_s) begin
          state_nxt_s = ST_GRANT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (release_s || timeout_hit_s) begin
          state_nxt_s = ST_RELEASE;
        end else begin
          state_nxt_s = ST_GRANT;
        end
      end
      ST_RELEASE: state_nxt_s = ST_IDLE;
      default:    state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output logic: next values of the registered outputs.
  always_comb begin
    grant_nxt_s   = 4'b0000;
    busy_nxt_s    = 1'b0;
    timeout_nxt_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (sel_vld_s) begin
          grant_nxt_s = onehot_of(sel_idx_s);
          busy_nxt_s  = 1'b1;
        end else begin
          grant_nxt_s = 4'b0000;
        end
      end
      ST_GRANT: begin
        if (release_s || timeout_hit_s) begin
          timeout_nxt_s = timeout_hit_s;
        end else begin
          grant_nxt_s = grant_r;
          busy_nxt_s  = 1'b1;
        end
      end
      ST_RELEASE: grant_nxt_s = 4'b0000;
      default:    grant_nxt_s = 4'b0000;
    endcase
  end

  // Registered outputs, credits, winner/last tracking and hold counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_r   <= 4'b0000;
      busy_r    <= 1'b0;
      timeout_r <= 1'b0;
      win_r     <= 2'd0;
      last_r    <= 2'd3;
      hold_r    <= 8'd0;
      for (int u = 0; u < 4; u++) begin
        cred_r[u] <= wt_of(2'(u));
      end
    end else begin
      grant_r   <= grant_nxt_s;
      busy_r    <= busy_nxt_s;
      timeout_r <= timeout_nxt_s;
      case (state_r)
        ST_IDLE: begin
          if (reload_s) begin
            for (int u = 0; u < 4; u++) begin
              cred_r[u] <= wt_of(2'(u));
            end
          end
          if (sel_vld_s) begin
            win_r  <= sel_idx_s;
            hold_r <= 8'd0;
          end
        end
        ST_GRANT: begin
          if (hold_r != 8'd255) begin
            hold_r <= hold_r + 8'd1;
          end
        end
        ST_RELEASE: begin
          // Credit is spent when the grant completes, not when it starts.
          if (cred_r[win_r] != 3'd0) begin
            cred_r[win_r] <= cred_r[win_r] - 3'd1;
          end
          last_r <= win_r;
        end
        default: begin
          hold_r <= 8'd0;
        end
      endcase
    end
  end

  assign bus.GRANT_O   = grant_r;
  assign bus.busy      = busy_r;
  assign bus.timeout_o = timeout_r;

endmodule

// File: tb/tb_arbiter_wrr.sv
// tb_arbiter_wrr
//   Directed bench for arbiter_wrr. dut_a uses unit weights and HOLD_MAX=4,
//   dut_b uses W1=3. Both see the same req/done/rst; each scenario resets
//   first and then checks only the instance it targets. Expected grants are
//   queued before stimulus and popped when the DUT asserts a grant.
module tb_arbiter_wrr;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_s;
  logic [3:0] done_s;

  always #5 clk = ~clk;

  arbiter_wrr_if a_if ();
  arbiter_wrr_if b_if ();

  assign a_if.req  = req_s;
  assign a_if.done = done_s;
  assign b_if.req  = req_s;
  assign b_if.done = done_s;

  arbiter_wrr #(.W1(1), .W2(1), .W3(1), .W4(1), .HOLD_MAX(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  arbiter_wrr #(.W1(3), .W2(1), .W3(1), .W4(1), .HOLD_MAX(16)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  int         total = 0;
  int         bad   = 0;
  logic [3:0] exp_q [$];
  int         lat;
  logic [3:0] g;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] gnt_of(input int sel);
    return (sel == 1) ? b_if.GRANT_O : a_if.GRANT_O;
  endfunction

  function automatic logic busy_of(input int sel);
    return (sel == 1) ? b_if.busy : a_if.busy;
  endfunction

  function automatic logic to_of(input int sel);
    return (sel == 1) ? b_if.timeout_o : a_if.timeout_o;
  endfunction

  task automatic do_reset;
    rst    = 1'b1;
    req_s  = 4'b0000;
    done_s = 4'b0000;
    tick;
    tick;
    chk("rst_grant_a", a_if.GRANT_O, 0);
    chk("rst_busy_a", a_if.busy, 0);
    chk("rst_timeout_a", a_if.timeout_o, 0);
    chk("rst_grant_b", b_if.GRANT_O, 0);
    rst = 1'b0;
  endtask

  // Wait (bounded) for a grant, then pop and compare the expected code.
  task automatic wait_grant(input int sel, input string tag,
                            output int lat_o, output logic [3:0] exp_o);
    logic [3:0] gv;
    gv    = 4'b0000;
    lat_o = 0;
    for (int n = 0; n < 20 && gv == 4'b0000; n++) begin
      tick;
      lat_o++;
      gv = gnt_of(sel);
    end
    if (exp_q.size() != 0) begin
      exp_o = exp_q.pop_front();
    end else begin
      exp_o = 4'b0000;
    end
    chk(tag, gv, exp_o);
  endtask

  // Each winner pulses done on its first grant cycle.
  task automatic run_seq(input int sel, input string tag, input int n);
    int         l;
    logic [3:0] e;
    for (int k = 0; k < n; k++) begin
      wait_grant(sel, {tag, "_grant"}, l, e);
      if (k > 0) begin
        chk({tag, "_bubble"}, l, 2);
      end
      done_s = e;
      tick;
      chk({tag, "_release"}, gnt_of(sel), 0);
      done_s = 4'b0000;
    end
  endtask

  initial begin
    rst    = 1'b1;
    req_s  = 4'b0000;
    done_s = 4'b0000;

    // Single requester, done on the third grant cycle, then regrant after reload.
    do_reset;
    req_s = 4'b1000;
    exp_q.push_back(4'b1000);
    wait_grant(0, "s1_grant", lat, g);
    chk("s1_latency", lat, 1);
    chk("s1_busy", a_if.busy, 1);
    tick;
    chk("s1_hold2", a_if.GRANT_O, 4'b1000);
    tick;
    chk("s1_hold3", a_if.GRANT_O, 4'b1000);
    done_s = 4'b1000;
    tick;
    chk("s1_release", a_if.GRANT_O, 0);
    chk("s1_busy_low", a_if.busy, 0);
    done_s = 4'b0000;
    exp_q.push_back(4'b1000);
    wait_grant(0, "s1_regrant", lat, g);
    chk("s1_regrant_latency", lat, 2);

    // Unit weights, all requesting.
    do_reset;
    req_s = 4'b1111;
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b1000);
    run_seq(0, "s2", 5);

    // W1=3: U1 spends leftover credits before the reload.
    do_reset;
    req_s = 4'b1111;
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0100);
    run_seq(1, "s3", 7);

    // Release by dropping req; the spent credit shows up in the later order.
    do_reset;
    req_s = 4'b1000;
    exp_q.push_back(4'b1000);
    wait_grant(1, "s4_grant", lat, g);
    req_s = 4'b0000;
    tick;
    chk("s4_release", b_if.GRANT_O, 0);
    chk("s4_timeout", b_if.timeout_o, 0);
    chk("s4_busy", b_if.busy, 0);
    req_s = 4'b1111;
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0100);
    run_seq(1, "s4b", 6);

    // Long hold: forced release with the watchdog, held grant without it.
    do_reset;
    req_s = 4'b0100;
    exp_q.push_back(4'b0100);
    wait_grant(0, "s5_grant", lat, g);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("s5_hold", a_if.GRANT_O, 4'b0100);
      chk("s5_no_timeout", a_if.timeout_o, 0);
    end
    tick;
`ifdef ARB_WRR_TIMEOUT_EN
    chk("s5_forced_release", a_if.GRANT_O, 0);
    chk("s5_timeout_pulse", a_if.timeout_o, 1);
    tick;
    chk("s5_timeout_end", a_if.timeout_o, 0);
    chk("s5_idle_grant", a_if.GRANT_O, 0);
`else
    chk("s5_still_held", a_if.GRANT_O, 4'b0100);
    chk("s5_timeout_tied", a_if.timeout_o, 0);
`endif
    req_s = 4'b0000;
    tick;
    tick;

    // Reset in the middle of a U3 grant.
    do_reset;
    req_s = 4'b0010;
    exp_q.push_back(4'b0010);
    wait_grant(0, "s6_grant", lat, g);
    tick;
    rst = 1'b1;
    tick;
    chk("s6_reset_grant", a_if.GRANT_O, 0);
    chk("s6_reset_busy", a_if.busy, 0);
    rst   = 1'b0;
    req_s = 4'b1111;
    exp_q.push_back(4'b1000);
    wait_grant(0, "s6_first_after_reset", lat, g);
    chk("s6_latency", lat, 1);

    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
